// File: rtl/memory_stage_dcache_pkg.sv
// Shared Y86-64 icode/status constants and M-stage cache FSM state type.
package memory_stage_dcache_pkg;

  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REFILL,
    ST_WRITE,
    ST_RESP
  } mstate_e;

  function automatic logic icode_is_read(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
  endfunction

  function automatic logic icode_is_write(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == IPUSHQ) || (icode == ICALL);
  endfunction

endpackage

// File: rtl/memory_stage_dcache_array.sv
// Direct-mapped line storage: combinational lookup, one synchronous write port,
// synchronous clear of all valid bits.
module dcache_array #(
  parameter int LINES = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = 57
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [IDX_W-1:0] lk_idx_i,
  input  logic [TAG_W-1:0] lk_tag_i,
  output logic             hit_o,
  output logic [63:0]      rdata_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic [63:0]      wr_data_i
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [63:0]      data_q [LINES];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only ever read under its valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign hit_o   = valid_q[lk_idx_i] && (tag_q[lk_idx_i] == lk_tag_i);
  assign rdata_o = data_q[lk_idx_i];

endmodule

// File: rtl/memory_stage_dcache.sv
// Y86-64 memory stage with a direct-mapped write-through, no-write-allocate cache.
//   state  | meaning
//   IDLE   | decode M instruction; hits, faults and bubbles complete here
//   REFILL | read miss outstanding on backing memory
//   WRITE  | write-through outstanding on backing memory
//   RESP   | present latched result for one cycle, then release
module memory_stage_dcache
  import memory_stage_dcache_pkg::*;
#(
  parameter int          LINES      = 16,
  parameter logic [63:0] ADDR_LIMIT = 64'h2000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [2:0]  M_stat_i,
  input  logic [3:0]  M_icode_i,
  input  logic [63:0] M_valE_i,
  input  logic [63:0] M_valA_i,
  output logic [2:0]  m_stat_o,
  output logic [63:0] m_valM_o,
  output logic        m_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [63:0] mem_rdata_i,
  input  logic        mem_err_i
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 61 - IDX_W;

  mstate_e     state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] lat_data_q, lat_data_d;
  logic [2:0]  lat_stat_q, lat_stat_d;

  logic        rd, wr, access, fault;
  logic [63:0] addr, lk_addr;
  logic        hit;
  logic [63:0] line_data;
  logic        arr_wr_en;

  assign rd     = icode_is_read(M_icode_i);
  assign wr     = icode_is_write(M_icode_i);
  assign addr   = ((M_icode_i == IPOPQ) || (M_icode_i == IRET)) ? M_valA_i : M_valE_i;
  assign access = (M_stat_i == SAOK) && (rd || wr);
  assign fault  = access && (addr >= ADDR_LIMIT);

  // While a transaction is outstanding, look up the captured address, not the live one.
  assign lk_addr = (state_q == ST_IDLE) ? addr : addr_q;

  dcache_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_array (
    .clk_i     (clk_i),
    .clr_i     (!rst_n_i),
    .lk_idx_i  (lk_addr[3 +: IDX_W]),
    .lk_tag_i  (lk_addr[63 -: TAG_W]),
    .hit_o     (hit),
    .rdata_o   (line_data),
    .wr_en_i   (arr_wr_en),
    .wr_idx_i  (addr_q[3 +: IDX_W]),
    .wr_tag_i  (addr_q[63 -: TAG_W]),
    .wr_data_i ((state_q == ST_REFILL) ? mem_rdata_i : wdata_q)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_data_q <= '0;
      lat_stat_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_data_q <= lat_data_d;
      lat_stat_q <= lat_stat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_data_d = lat_data_q;
    lat_stat_d = lat_stat_q;
    arr_wr_en  = 1'b0;
    m_stall_o  = 1'b0;
    m_stat_o   = M_stat_i;
    m_valM_o   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (fault) begin
          m_stat_o = SADR;
        end else if (access) begin
          if (rd && hit) begin
            m_valM_o = line_data;
          end else begin
            m_stall_o = 1'b1;
            addr_d    = addr & ~64'd7;
            wdata_d   = M_valA_i;
            state_d   = rd ? ST_REFILL : ST_WRITE;
          end
        end
      end
      ST_REFILL: begin
        m_stall_o = 1'b1;
        if (mem_ack_i) begin
          arr_wr_en  = !mem_err_i;
          lat_data_d = mem_err_i ? 64'd0 : mem_rdata_i;
          lat_stat_d = mem_err_i ? SADR : SAOK;
          state_d    = ST_RESP;
        end
      end
      ST_WRITE: begin
        m_stall_o = 1'b1;
        if (mem_ack_i) begin
          arr_wr_en  = !mem_err_i && hit;
          lat_data_d = '0;
          lat_stat_d = mem_err_i ? SADR : SAOK;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        m_stat_o = lat_stat_q;
        m_valM_o = lat_data_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req_o   = (state_q == ST_REFILL) || (state_q == ST_WRITE);
  assign mem_we_o    = (state_q == ST_WRITE);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_memory_stage_dcache.sv
// Directed bench for memory_stage_dcache: miss/hit timing, write-through,
// no-allocate, faults, bus error, reset mid-refill and status passthrough.
module tb_memory_stage_dcache;
  import memory_stage_dcache_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [2:0]  M_stat_i;
  logic [3:0]  M_icode_i;
  logic [63:0] M_valE_i, M_valA_i;
  logic [2:0]  m_stat_o;
  logic [63:0] m_valM_o;
  logic        m_stall_o, mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i, mem_err_i;
  logic [63:0] mem_rdata_i;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  memory_stage_dcache dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .M_stat_i    (M_stat_i),
    .M_icode_i   (M_icode_i),
    .M_valE_i    (M_valE_i),
    .M_valA_i    (M_valA_i),
    .m_stat_o    (m_stat_o),
    .m_valM_o    (m_valM_o),
    .m_stall_o   (m_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_err_i   (mem_err_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [63:0] vale, input logic [63:0] vala);
    M_icode_i = icode;
    M_valE_i  = vale;
    M_valA_i  = vala;
  endtask

  initial begin
    rst_n_i = 1'b0;
    M_stat_i = SAOK;
    drive(INOP, 64'd0, 64'd0);
    mem_ack_i = 1'b0;
    mem_err_i = 1'b0;
    mem_rdata_i = '0;
    tick();
    tick();
    rst_n_i = 1'b1;
    settle();
    chk("rst_stall", 64'(m_stall_o), 64'd0);
    chk("rst_req",   64'(mem_req_o), 64'd0);
    chk("rst_we",    64'(mem_we_o),  64'd0);
    chk("rst_addr",  mem_addr_o, 64'd0);
    chk("rst_wdata", mem_wdata_o, 64'd0);
    chk("rst_valM",  m_valM_o, 64'd0);

    // Cold read of 0x100: stall in IDLE + 3 REFILL cycles
    drive(IMRMOVQ, 64'h100, 64'd0);
    settle();
    chk("cold_stall_idle", 64'(m_stall_o), 64'd1);
    chk("cold_req_idle",   64'(mem_req_o), 64'd0);
    tick();
    settle();
    chk("cold_req1",  64'(mem_req_o), 64'd1);
    chk("cold_we1",   64'(mem_we_o),  64'd0);
    chk("cold_addr1", mem_addr_o, 64'h100);
    chk("cold_stall1", 64'(m_stall_o), 64'd1);
    tick();
    settle();
    chk("cold_req2", 64'(mem_req_o), 64'd1);
    tick();
    mem_ack_i = 1'b1;
    mem_rdata_i = 64'hDEAD;
    settle();
    chk("cold_stall_ack", 64'(m_stall_o), 64'd1);
    tick();
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    settle();
    chk("cold_resp_stall", 64'(m_stall_o), 64'd0);
    chk("cold_resp_valM",  m_valM_o, 64'hDEAD);
    chk("cold_resp_stat",  64'(m_stat_o), 64'(SAOK));
    chk("cold_resp_req",   64'(mem_req_o), 64'd0);
    tick();
    settle();
    chk("hit_stall", 64'(m_stall_o), 64'd0);
    chk("hit_valM",  m_valM_o, 64'hDEAD);
    chk("hit_req",   64'(mem_req_o), 64'd0);

    // Write-through hit
    drive(IRMMOVQ, 64'h100, 64'h55);
    settle();
    chk("wr_stall_idle", 64'(m_stall_o), 64'd1);
    tick();
    settle();
    chk("wr_req",   64'(mem_req_o), 64'd1);
    chk("wr_we",    64'(mem_we_o),  64'd1);
    chk("wr_addr",  mem_addr_o, 64'h100);
    chk("wr_wdata", mem_wdata_o, 64'h55);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    settle();
    chk("wr_resp_stall", 64'(m_stall_o), 64'd0);
    chk("wr_resp_valM",  m_valM_o, 64'd0);
    chk("wr_resp_stat",  64'(m_stat_o), 64'(SAOK));
    tick();
    drive(IMRMOVQ, 64'h100, 64'd0);
    settle();
    chk("wrhit_valM",  m_valM_o, 64'h55);
    chk("wrhit_stall", 64'(m_stall_o), 64'd0);
    chk("wrhit_req",   64'(mem_req_o), 64'd0);

    // Write miss, no allocate
    drive(IPUSHQ, 64'h200, 64'h77);
    settle();
    chk("push_stall", 64'(m_stall_o), 64'd1);
    tick();
    settle();
    chk("push_req",   64'(mem_req_o), 64'd1);
    chk("push_we",    64'(mem_we_o),  64'd1);
    chk("push_addr",  mem_addr_o, 64'h200);
    chk("push_wdata", mem_wdata_o, 64'h77);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    tick();
    drive(IMRMOVQ, 64'h200, 64'd0);
    settle();
    chk("noalloc_miss_stall", 64'(m_stall_o), 64'd1);
    tick();
    settle();
    chk("noalloc_req",  64'(mem_req_o), 64'd1);
    chk("noalloc_we",   64'(mem_we_o),  64'd0);
    chk("noalloc_addr", mem_addr_o, 64'h200);
    mem_ack_i = 1'b1;
    mem_rdata_i = 64'hABC;
    tick();
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    settle();
    chk("noalloc_valM", m_valM_o, 64'hABC);

    // Bus error on refill of 0x308
    tick();
    drive(IMRMOVQ, 64'h308, 64'd0);
    settle();
    chk("err_stall", 64'(m_stall_o), 64'd1);
    tick();
    mem_ack_i = 1'b1;
    mem_err_i = 1'b1;
    mem_rdata_i = 64'h999;
    tick();
    mem_ack_i = 1'b0;
    mem_err_i = 1'b0;
    mem_rdata_i = '0;
    settle();
    chk("err_stat",  64'(m_stat_o), 64'(SADR));
    chk("err_valM",  m_valM_o, 64'd0);
    chk("err_stall_resp", 64'(m_stall_o), 64'd0);
    tick();
    settle();
    chk("err_line_invalid", 64'(m_stall_o), 64'd1);

    // Reset while REFILL of 0x308 is outstanding
    tick();
    settle();
    chk("rst_mid_req_before", 64'(mem_req_o), 64'd1);
    rst_n_i = 1'b0;
    tick();
    rst_n_i = 1'b1;
    mem_ack_i = 1'b1;
    drive(INOP, 64'd0, 64'd0);
    settle();
    chk("rst_mid_req",   64'(mem_req_o), 64'd0);
    chk("rst_mid_stall", 64'(m_stall_o), 64'd0);
    tick();
    mem_ack_i = 1'b0;
    settle();
    chk("post_rst_ack_ignored", 64'(mem_req_o), 64'd0);
    drive(IMRMOVQ, 64'h200, 64'd0);
    settle();
    chk("post_rst_miss", 64'(m_stall_o), 64'd1);
    tick();
    mem_ack_i = 1'b1;
    mem_rdata_i = 64'h200;
    tick();
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    settle();
    chk("post_rst_refill_valM", m_valM_o, 64'h200);

    // Address fault via valA (popq)
    tick();
    drive(IPOPQ, 64'd0, 64'h2000);
    settle();
    chk("pop_fault_stat",  64'(m_stat_o), 64'(SADR));
    chk("pop_fault_req",   64'(mem_req_o), 64'd0);
    chk("pop_fault_stall", 64'(m_stall_o), 64'd0);
    tick();
    settle();
    chk("pop_fault_noreq_next", 64'(mem_req_o), 64'd0);

    // Address fault via valE and last legal word
    drive(IMRMOVQ, 64'h2000, 64'd0);
    settle();
    chk("ld_fault_stat",  64'(m_stat_o), 64'(SADR));
    chk("ld_fault_stall", 64'(m_stall_o), 64'd0);

    // Non-SAOK passthrough
    M_stat_i = SHLT;
    drive(IMRMOVQ, 64'h100, 64'd0);
    settle();
    chk("shlt_stat",  64'(m_stat_o), 64'(SHLT));
    chk("shlt_stall", 64'(m_stall_o), 64'd0);
    chk("shlt_req",   64'(mem_req_o), 64'd0);
    chk("shlt_valM",  m_valM_o, 64'd0);

    // Spurious ack in IDLE
    M_stat_i = SAOK;
    drive(INOP, 64'd0, 64'd0);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    settle();
    chk("spur_ack_req",   64'(mem_req_o), 64'd0);
    chk("spur_ack_stall", 64'(m_stall_o), 64'd0);

    drive(IMRMOVQ, 64'h1FF8, 64'd0);
    settle();
    chk("limit_minus8_stat",  64'(m_stat_o), 64'(SAOK));
    chk("limit_minus8_stall", 64'(m_stall_o), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_stage_dcache.md
Name: memory_stage_dcache

Overview:
- Memory (M) stage of the pipelined Y86-64 core, fronted by a direct-mapped, write-through data cache.
- Takes M-register fields, computes the access address, and services reads and writes via the cache or an external backing-memory handshake.
- Produces m_stat and m_valM for the M→W pipeline register.
- Raises m_stall_o while a backing-memory transaction is outstanding; pipeline control then stalls F/D/E/M and bubbles W.

Parameters:
- LINES, 16, number of cache lines (power of 2); one 64-bit word per line.
- ADDR_LIMIT, 64'h2000, first illegal byte address; any access with addr ≥ ADDR_LIMIT is a fault.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- M_stat_i  in  3  status from M register
- M_icode_i  in  4  icode from M register
- M_valE_i  in  64  ALU result
- M_valA_i  in  64  operand A / store data
- m_stat_o  out  3  stage status to W register
- m_valM_o  out  64  load data to W register
- m_stall_o  out  1  stage busy; hold M and earlier, bubble W
- mem_req_o  out  1  backing-memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  64  word-aligned address (addr & ~7)
- mem_wdata_o  out  64  write data
- mem_ack_i  in  1  one-cycle completion pulse
- mem_rdata_i  in  64  read data, valid with ack
- mem_err_i  in  1  bus error, valid with ack

Behaviour:
- Decode:
  - read = icode ∈ {IMRMOVQ, IPOPQ, IRET}; write = icode ∈ {IRMMOVQ, IPUSHQ, ICALL}.
  - addr = valA for IPOPQ/IRET, else valE.
  - wdata = valA.
- No access when M_stat_i ≠ SAOK.
- index = addr[3+log2(LINES)-1 : 3]; tag = addr[63 : 3+log2(LINES)].
- FSM states: IDLE, REFILL, WRITE, RESP.
- IDLE:
  - No access → m_valM = 0, stall = 0.
  - addr ≥ ADDR_LIMIT → m_stat = SADR, no memory request, stall = 0.
  - Read hit → m_valM = line data combinationally, stall = 0 (zero-cycle latency).
  - Read miss → stall = 1, go to REFILL.
  - Write (hit or miss) → stall = 1, go to WRITE.
- REFILL:
  - mem_req = 1, we = 0, stall = 1; req held until ack.
  - On ack without err: write line, set valid and tag, latch data, go to RESP.
  - On ack with err: line not filled, latch SADR, go to RESP.
- WRITE:
  - mem_req = 1, we = 1, stall = 1.
  - On ack without err: if hit, update line data (no-allocate on miss); go to RESP.
  - On ack with err: latch SADR, cache unchanged, go to RESP.
- RESP:
  - stall = 0; m_valM = latched data (0 for writes); m_stat = latched status.
  - Next state IDLE; no reissue of the same M instruction.
- Miss latency: ack cycle + 1; stall spans request cycles through the ack cycle.
- m_stat = M_stat_i unless a fault is flagged as above.
- mem_addr and mem_wdata are registered when entering REFILL/WRITE and held stable while req = 1.
- Reset (any cycle, including mid-transaction):
  - State → IDLE; all valid bits cleared; mem_req_o = 0; latched data and status cleared.
  - An ack arriving in the cycle after reset is ignored.
- A spurious ack in IDLE or RESP is ignored.
- Outputs with state at reset: m_stall_o = 0, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0; m_valM_o = 0 when M is a bubble.

Decomposition:
- Shared define file: icode constants (INOP, IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ) and status codes SAOK = 1, SHLT = 2, SADR = 3, SINS = 4.
- Sub-module dcache_array: valid/tag/data storage; combinational lookup (hit, rdata); one synchronous write port (fill or update); synchronous clear of valid bits.
- FSM and decode stay in memory_stage_dcache.

Test Plan:
- Cold read: mrmovq, valE = 0x100, ack after 3 cycles with rdata = 0xDEAD → stall high for 4 cycles, RESP m_valM = 0xDEAD, m_stat = SAOK. Repeat access → hit, stall = 0, same data in the same cycle.
- Write-through hit: after the above, rmmovq valE = 0x100, valA = 0x55 → one req with we = 1, addr = 0x100, wdata = 0x55. Next mrmovq of 0x100 hits, returns 0x55 with no req.
- Write miss no-allocate: pushq, valE = 0x200 → write issued. A subsequent read of 0x200 misses and issues a REFILL.
- Faults: popq with valA = 0x2000 → m_stat = SADR, no mem_req, stall = 0. Read with ack + err → m_stat = SADR in RESP, line not valid afterwards.
- Reset mid-REFILL: rst_n_i low one cycle while req = 1 → req drops the next cycle, state IDLE, previously valid 0x100 now misses.
- Non-SAOK passthrough: M_stat_i = SHLT with mrmovq → no req, m_stat = SHLT, stall = 0.
